// File: rtl/fetch_unit.sv
// Instruction fetch unit: computes the fetch address, issues one memory read
// per accepted request, captures the returned word and flags fetch timeouts.
module fetch_unit (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PC_EN,
  input  logic [1:0]  PC_MUX_SEL,
  input  logic [15:0] TARGET,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [15:0] IMEM_RDATA,
  output logic [15:0] INST,
  output logic        INST_VALID,
  output logic [15:0] PC,
  output logic        FETCH_BUSY,
  output logic        FETCH_ERR
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_REL = 2'b01;
  localparam logic [1:0] SEL_ABS = 2'b10;

  localparam logic [DW-1:0] INST_RESET = 16'hF000;
  localparam logic [CW-1:0] WAIT_MAX   = 4'd15;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] pc_nxt, addr_nxt;
  logic [DW-1:0] inst_nxt;
  logic          valid_nxt, err_nxt, req_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic [AW-1:0] fetch_addr_c;

  // Fetch address mux; the relative mode adds a two's-complement offset mod 2^16.
  always_comb begin
    fetch_addr_c = PC;
    case (PC_MUX_SEL)
      SEL_PC:  fetch_addr_c = PC;
      SEL_REL: fetch_addr_c = AW'(PC + TARGET);
      SEL_ABS: fetch_addr_c = TARGET;
      default: fetch_addr_c = '0;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      PC         <= '0;
      IMEM_ADDR  <= '0;
      INST       <= INST_RESET;
      INST_VALID <= 1'b0;
      IMEM_REQ   <= 1'b0;
      FETCH_ERR  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      PC         <= pc_nxt;
      IMEM_ADDR  <= addr_nxt;
      INST       <= inst_nxt;
      INST_VALID <= valid_nxt;
      IMEM_REQ   <= req_nxt;
      FETCH_ERR  <= err_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    addr_nxt  = IMEM_ADDR;
    inst_nxt  = INST;
    valid_nxt = INST_VALID;
    err_nxt   = FETCH_ERR;
    req_nxt   = IMEM_REQ;
    wait_nxt  = wait_cnt;

    case (state)
      ST_IDLE, ST_HOLD: begin
        if (PC_EN) begin
          state_nxt = ST_REQ;
          addr_nxt  = fetch_addr_c;
          valid_nxt = 1'b0;
          err_nxt   = 1'b0;
          req_nxt   = 1'b1;
          wait_nxt  = '0;
        end
      end
      ST_REQ: begin
        // ACK takes priority over a coincident timeout.
        if (IMEM_ACK) begin
          state_nxt = ST_HOLD;
          inst_nxt  = IMEM_RDATA;
          pc_nxt    = AW'(IMEM_ADDR + AW'(1));
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
        end else if (wait_cnt == WAIT_MAX) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
        end else begin
          wait_nxt = CW'(wait_cnt + CW'(1));
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  assign FETCH_BUSY = IMEM_REQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// timeout/reset sequences and randomized traffic against a transaction model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PC_EN;
  logic [1:0]  PC_MUX_SEL;
  logic [15:0] TARGET;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_RDATA;
  logic [15:0] INST;
  logic        INST_VALID;
  logic [15:0] PC;
  logic        FETCH_BUSY;
  logic        FETCH_ERR;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N), .PC_EN(PC_EN), .PC_MUX_SEL(PC_MUX_SEL),
    .TARGET(TARGET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .INST(INST),
    .INST_VALID(INST_VALID), .PC(PC), .FETCH_BUSY(FETCH_BUSY),
    .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  // Transaction-level model: one outstanding read with an age in cycles.
  logic [15:0] m_pc, m_addr, m_inst;
  logic        m_valid, m_err, m_busy;
  int          m_age;

  task automatic model_reset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_inst = 16'hF000;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_age = 0;
  endtask

  task automatic model_edge();
    int sum;
    if (!m_busy) begin
      if (PC_EN) begin
        sum = int'(m_pc) + int'(TARGET);
        case (PC_MUX_SEL)
          2'b00: m_addr = m_pc;
          2'b01: m_addr = 16'(sum % 65536);
          2'b10: m_addr = TARGET;
          default: m_addr = 16'h0000;
        endcase
        m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b1; m_age = 0;
      end
    end else if (IMEM_ACK) begin
      m_inst = IMEM_RDATA;
      m_pc = 16'((int'(m_addr) + 1) % 65536);
      m_valid = 1'b1; m_busy = 1'b0;
    end else begin
      m_age++;
      if (m_age == 16) begin
        m_err = 1'b1; m_busy = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " req"},   16'(IMEM_REQ),   16'(m_busy));
    chk({tag, " busy"},  16'(FETCH_BUSY), 16'(m_busy));
    chk({tag, " addr"},  IMEM_ADDR, m_addr);
    chk({tag, " inst"},  INST, m_inst);
    chk({tag, " valid"}, 16'(INST_VALID), 16'(m_valid));
    chk({tag, " pc"},    PC, m_pc);
    chk({tag, " err"},   16'(FETCH_ERR), 16'(m_err));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] sel, input logic [15:0] tgt,
                       input logic ack, input logic [15:0] rd);
    PC_EN = en; PC_MUX_SEL = sel; TARGET = tgt; IMEM_ACK = ack; IMEM_RDATA = rd;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic [15:0] inst;
    logic        valid;
    logic [15:0] pc;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string tag;
    int cnt;
    logic [15:0] pc_before;

    //             en sel    tgt      ack rdata     req addr     inst     vld pc       err
    vecs[0]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h1234, 1'b1, 16'h0001, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 16'h000F, 1'b0, 16'h0000, 1'b1, 16'h000F, 16'h1234, 1'b0, 16'h0001, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'hAAAA, 1'b0, 16'h000F, 16'hAAAA, 1'b1, 16'h0010, 1'b0};
    vecs[4]  = '{1'b1, 2'b01, 16'hFFFC, 1'b0, 16'h0000, 1'b1, 16'h000C, 16'hAAAA, 1'b0, 16'h0010, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 16'h5555, 1'b0, 16'h0000, 1'b1, 16'h000C, 16'hAAAA, 1'b0, 16'h0010, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'hBBBB, 1'b0, 16'h000C, 16'hBBBB, 1'b1, 16'h000D, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'hCCCC, 1'b0, 16'h000C, 16'hBBBB, 1'b1, 16'h000D, 1'b0};
    vecs[8]  = '{1'b1, 2'b10, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'hBBBB, 1'b0, 16'h000D, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'hFFFF, 16'h1111, 1'b1, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 2'b11, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1111, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h2222, 1'b0, 16'h0000, 16'h2222, 1'b1, 16'h0001, 1'b0};

    do_reset();
    chk("rst req",   16'(IMEM_REQ), 16'h0);
    chk("rst busy",  16'(FETCH_BUSY), 16'h0);
    chk("rst addr",  IMEM_ADDR, 16'h0000);
    chk("rst inst",  INST, 16'hF000);
    chk("rst valid", 16'(INST_VALID), 16'h0);
    chk("rst pc",    PC, 16'h0000);
    chk("rst err",   16'(FETCH_ERR), 16'h0);

    // Directed vector table, one row per clock edge.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].sel, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
      tick();
      tag = $sformatf("vec%0d", i);
      chk({tag, " req"},   16'(IMEM_REQ),   16'(vecs[i].req));
      chk({tag, " busy"},  16'(FETCH_BUSY), 16'(vecs[i].req));
      chk({tag, " addr"},  IMEM_ADDR, vecs[i].addr);
      chk({tag, " inst"},  INST, vecs[i].inst);
      chk({tag, " valid"}, 16'(INST_VALID), 16'(vecs[i].valid));
      chk({tag, " pc"},    PC, vecs[i].pc);
      chk({tag, " err"},   16'(FETCH_ERR), 16'(vecs[i].err));
    end

    // Timeout: request held for exactly 16 cycles, then error with PC untouched.
    pc_before = PC;
    drive(1'b1, 2'b10, 16'h0040, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    cnt = 0;
    while (IMEM_REQ === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("timeout req cycles", 16'(cnt), 16'd16);
    chk("timeout err", 16'(FETCH_ERR), 16'h1);
    chk("timeout pc", PC, pc_before);
    chk("timeout inst", INST, 16'h2222);
    chk("timeout valid", 16'(INST_VALID), 16'h0);
    tick();
    chk("timeout err sticky", 16'(FETCH_ERR), 16'h1);
    drive(1'b1, 2'b00, 16'h0000, 1'b0, 16'h0000);
    tick();
    chk("err cleared on accept", 16'(FETCH_ERR), 16'h0);
    chk("accept after timeout addr", IMEM_ADDR, pc_before);

    // ACK on the last wait cycle wins over the timeout.
    drive(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    repeat (15) tick();
    chk("late ack still req", 16'(IMEM_REQ), 16'h1);
    drive(1'b0, 2'b00, 16'h0000, 1'b1, 16'h7777);
    tick();
    chk("late ack inst", INST, 16'h7777);
    chk("late ack valid", 16'(INST_VALID), 16'h1);
    chk("late ack err", 16'(FETCH_ERR), 16'h0);
    chk("late ack pc", PC, 16'(pc_before + 16'h1));

    // Reset mid-request acts without a clock edge; a later ACK is ignored.
    drive(1'b1, 2'b10, 16'h0300, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    chk("pre-reset req", 16'(IMEM_REQ), 16'h1);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("async rst req", 16'(IMEM_REQ), 16'h0);
    chk("async rst busy", 16'(FETCH_BUSY), 16'h0);
    chk("async rst inst", INST, 16'hF000);
    chk("async rst pc", PC, 16'h0000);
    chk("async rst addr", IMEM_ADDR, 16'h0000);
    #1;
    RST_N = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 1'b1, 16'hDEAD);
    tick();
    chk("ack after reset inst", INST, 16'hF000);
    chk("ack after reset valid", 16'(INST_VALID), 16'h0);
    chk("ack after reset req", 16'(IMEM_REQ), 16'h0);
    repeat (3) tick();
    chk("idle without pc_en", 16'(IMEM_REQ), 16'h0);

    // Randomized traffic against the model; second half starves ACK to hit timeouts.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            (c < 1000) ? 1'($urandom_range(0, 99) < 40) : 1'($urandom_range(0, 99) < 4),
            16'($urandom));
      tick();
      chk_model($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
